pipe_ctrl_hazard: RTL

Consumer end of the main/ALU decoder control interface in the 5-stage pipelined RISC-V core. Takes decode-stage (D) control bundles and register addresses, and carries them through the ID/EX, EX/MEM and MEM/WB control registers. Produces per-stage control, branch resolution (PCSrc), load-use stall, flush, and forwarding selects for the EX-stage operand muxes.

---
 rtl/pipe_ctrl_hazard.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl_hazard.sv
// pipe_ctrl_hazard
// Control-side pipeline for the 5-stage RISC-V core. Carries decoder control
// bundles through the ID/EX, EX/MEM and MEM/WB registers. Resolves branches
// and jumps, detects load-use hazards and generates the EX-stage forwarding
// selects.
//
// Ports:
//   clk, rst            pipeline clock (rising edge), async active-high reset
//   *_D                 decoder control bundle and register addresses (D stage)
//   Zero_E              ALU zero flag from the EX stage
//   ALUControl_E        EX ALU operation
//   ALUSrc_E            EX operand-B select
//   PCSrc_E             redirect PC to the branch/jump target
//   MemWrite_M          data-memory write enable
//   RegWrite_W          register-file write enable
//   ResultSrc_W         writeback mux select (00 ALU, 01 mem, 10 PC+4)
//   Rd_W                register-file write address
//   ForwardA/B_E        00 regfile, 01 WB result, 10 MEM ALU result
//   Stall_F, Stall_D    hold PC / IF-ID register
//   Flush_D, Flush_E    bubble IF-ID / ID-EX register
module pipe_ctrl_hazard #(
  parameter int REG_AW = 5,
  parameter int ALUC_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite_D,
  input  logic [1:0]        ResultSrc_D,
  input  logic              MemWrite_D,
  input  logic              Jump_D,
  input  logic              Branch_D,
  input  logic [ALUC_W-1:0] ALUControl_D,
  input  logic              ALUSrc_D,
  input  logic [REG_AW-1:0] Rs1_D,
  input  logic [REG_AW-1:0] Rs2_D,
  input  logic [REG_AW-1:0] Rd_D,
  input  logic              Zero_E,
  output logic [ALUC_W-1:0] ALUControl_E,
  output logic              ALUSrc_E,
  output logic              PCSrc_E,
  output logic              MemWrite_M,
  output logic              RegWrite_W,
  output logic [1:0]        ResultSrc_W,
  output logic [REG_AW-1:0] Rd_W,
  output logic [1:0]        ForwardA_E,
  output logic [1:0]        ForwardB_E,
  output logic              Stall_F,
  output logic              Stall_D,
  output logic              Flush_D,
  output logic              Flush_E
);

  // ID/EX
  logic              reg_write_e_q, reg_write_e_d;
  logic [1:0]        result_src_e_q, result_src_e_d;
  logic              mem_write_e_q, mem_write_e_d;
  logic              jump_e_q, jump_e_d;
  logic              branch_e_q, branch_e_d;
  logic [ALUC_W-1:0] alu_control_e_q, alu_control_e_d;
  logic              alu_src_e_q, alu_src_e_d;
  logic [REG_AW-1:0] rs1_e_q, rs1_e_d;
  logic [REG_AW-1:0] rs2_e_q, rs2_e_d;
  logic [REG_AW-1:0] rd_e_q, rd_e_d;
  // EX/MEM
  logic              reg_write_m_q, reg_write_m_d;
  logic [1:0]        result_src_m_q, result_src_m_d;
  logic              mem_write_m_q, mem_write_m_d;
  logic [REG_AW-1:0] rd_m_q, rd_m_d;
  // MEM/WB
  logic              reg_write_w_q, reg_write_w_d;
  logic [1:0]        result_src_w_q, result_src_w_d;
  logic [REG_AW-1:0] rd_w_q, rd_w_d;

  logic pc_src_e;
  logic lw_stall;
  logic flush_e;

  assign pc_src_e = (branch_e_q & Zero_E) | jump_e_q;

  // A load in E whose destination is read by the instruction in D.
  assign lw_stall = (result_src_e_q == 2'b01) && (rd_e_q != '0) &&
                    ((rd_e_q == Rs1_D) || (rd_e_q == Rs2_D));

  // A redirect makes the stalled instruction dead anyway, so it overrides the stall.
  assign Stall_F = lw_stall & ~pc_src_e;
  assign Stall_D = lw_stall & ~pc_src_e;
  assign flush_e = lw_stall | pc_src_e;
  assign Flush_E = flush_e;
  assign Flush_D = pc_src_e;

  always_comb begin
    reg_write_e_d   = RegWrite_D;
    result_src_e_d  = ResultSrc_D;
    mem_write_e_d   = MemWrite_D;
    jump_e_d        = Jump_D;
    branch_e_d      = Branch_D;
    alu_control_e_d = ALUControl_D;
    alu_src_e_d     = ALUSrc_D;
    rs1_e_d         = Rs1_D;
    rs2_e_d         = Rs2_D;
    rd_e_d          = Rd_D;
    if (flush_e) begin
      reg_write_e_d   = 1'b0;
      result_src_e_d  = '0;
      mem_write_e_d   = 1'b0;
      jump_e_d        = 1'b0;
      branch_e_d      = 1'b0;
      alu_control_e_d = '0;
      alu_src_e_d     = 1'b0;
      rs1_e_d         = '0;
      rs2_e_d         = '0;
      rd_e_d          = '0;
    end
    reg_write_m_d  = reg_write_e_q;
    result_src_m_d = result_src_e_q;
    mem_write_m_d  = mem_write_e_q;
    rd_m_d         = rd_e_q;
    reg_write_w_d  = reg_write_m_q;
    result_src_w_d = result_src_m_q;
    rd_w_d         = rd_m_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_e_q   <= 1'b0;
      result_src_e_q  <= '0;
      mem_write_e_q   <= 1'b0;
      jump_e_q        <= 1'b0;
      branch_e_q      <= 1'b0;
      alu_control_e_q <= '0;
      alu_src_e_q     <= 1'b0;
      rs1_e_q         <= '0;
      rs2_e_q         <= '0;
      rd_e_q          <= '0;
      reg_write_m_q   <= 1'b0;
      result_src_m_q  <= '0;
      mem_write_m_q   <= 1'b0;
      rd_m_q          <= '0;
      reg_write_w_q   <= 1'b0;
      result_src_w_q  <= '0;
      rd_w_q          <= '0;
    end else begin
      reg_write_e_q   <= reg_write_e_d;
      result_src_e_q  <= result_src_e_d;
      mem_write_e_q   <= mem_write_e_d;
      jump_e_q        <= jump_e_d;
      branch_e_q      <= branch_e_d;
      alu_control_e_q <= alu_control_e_d;
      alu_src_e_q     <= alu_src_e_d;
      rs1_e_q         <= rs1_e_d;
      rs2_e_q         <= rs2_e_d;
      rd_e_q          <= rd_e_d;
      reg_write_m_q   <= reg_write_m_d;
      result_src_m_q  <= result_src_m_d;
      mem_write_m_q   <= mem_write_m_d;
      rd_m_q          <= rd_m_d;
      reg_write_w_q   <= reg_write_w_d;
      result_src_w_q  <= result_src_w_d;
      rd_w_q          <= rd_w_d;
    end
  end

  // MEM result is younger than WB, so it wins; x0 is hardwired and never forwarded.
  always_comb begin
    ForwardA_E = 2'b00;
    ForwardB_E = 2'b00;
    if (reg_write_m_q && (rd_m_q != '0) && (rd_m_q == rs1_e_q))
      ForwardA_E = 2'b10;
    else if (reg_write_w_q && (rd_w_q != '0) && (rd_w_q == rs1_e_q))
      ForwardA_E = 2'b01;
    if (reg_write_m_q && (rd_m_q != '0) && (rd_m_q == rs2_e_q))
      ForwardB_E = 2'b10;
    else if (reg_write_w_q && (rd_w_q != '0) && (rd_w_q == rs2_e_q))
      ForwardB_E = 2'b01;
  end

  assign ALUControl_E = alu_control_e_q;
  assign ALUSrc_E     = alu_src_e_q;
  assign PCSrc_E      = pc_src_e;
  assign MemWrite_M   = mem_write_m_q;
  assign RegWrite_W   = reg_write_w_q;
  assign ResultSrc_W  = result_src_w_q;
  assign Rd_W         = rd_w_q;

endmodule
